// File: rtl/tdm_mux_4_1_pkg.sv
// Shared constants for the TDM gathering multiplexer and its matching demultiplexer.
package tdm_mux_4_1_pkg;
  localparam int DEFAULT_CHANNELS    = 4;
  localparam int CHANNEL_IDX_WIDTH   = $clog2(DEFAULT_CHANNELS);
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_COUNT_WIDTH = 16;
endpackage

// File: rtl/tdm_mux_4_1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module rr_arbiter
  import tdm_mux_4_1_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                any_grant_o
);

  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Search from the pointer upward; IDX_W-bit addition wraps because CHANNELS is a power of 2.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    idx_s       = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      idx_s = ptr_i + IDX_W'(off);
      if (!found_s && req_i[idx_s]) begin
        grant_o[idx_s] = 1'b1;
        grant_idx_o    = idx_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any_grant_o = |req_i;
  end

endmodule

// File: rtl/tdm_mux_4_1.sv
// N:1 gathering multiplexer: round-robin merge of valid/ready streams into one
// registered output tagged with its source channel.
module tdm_mux_4_1
  import tdm_mux_4_1_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int IDX_W       = $clog2(CHANNELS)
) (
  input  logic                         Clock_In,
  input  logic                         Reset_In,
  input  logic                         Enable_In,
  input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
  input  logic [CHANNELS-1:0]          Valid_In,
  output logic [CHANNELS-1:0]          Ready_Out,
  output logic [DATA_WIDTH-1:0]        Mux_Data_Out,
  output logic [IDX_W-1:0]             Mux_Channel_Out,
  output logic                         Mux_Valid_Out,
  input  logic                         Mux_Ready_In,
  output logic [COUNT_WIDTH-1:0]       Word_Count_Out
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      chan_q, chan_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [CHANNELS-1:0]   grant_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic                  any_grant_s;
  logic                  slot_free_s;
  logic                  drain_s;
  logic                  load_s;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i       (Valid_In),
    .ptr_i       (ptr_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .any_grant_o (any_grant_s)
  );

  // Reset is folded into load so no accept strobe escapes during reset.
  assign drain_s     = valid_q && Mux_Ready_In;
  assign slot_free_s = !valid_q || Mux_Ready_In;
  assign load_s      = Enable_In && slot_free_s && any_grant_s && !Reset_In;
  assign Ready_Out   = load_s ? grant_s : '0;

  // Next-state for the output slot, round-robin pointer and delivered-word counter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = Data_In[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
      chan_d  = grant_idx_s;
      ptr_d   = grant_idx_s + IDX_W'(1);
    end else if (drain_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drain_s) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign Mux_Valid_Out   = valid_q;
  assign Mux_Data_Out    = data_q;
  assign Mux_Channel_Out = chan_q;
  assign Word_Count_Out  = count_q;

endmodule
